// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - instruction fields in, datapath controls out
interface multicycle_ctrl_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [3:0] Flags;
  logic [3:0] State;

  modport master (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, Flags, State
  );

  modport slave (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, Flags, State
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle Moore control FSM with flags and condition gating
module multicycle_ctrl (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_ctrl_if.master    bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic       condex_q, condex_d;
  logic [3:0] flags_q, flags_d;

  logic [3:0] cmd;
  logic       s_bit;
  logic [1:0] alu_op;
  logic       no_write;
  logic       is_cmp;
  logic       is_nop;
  logic [1:0] flag_w;
  logic       pcs;
  logic       cond_ok;
  logic       flag_z, flag_c, flag_n, flag_v, ge;

  assign cmd   = bus.Funct[4:1];
  assign s_bit = bus.Funct[0];
  assign pcs   = (bus.Rd == 4'd15);

  always_comb begin
    alu_op   = 2'b00;
    no_write = 1'b0;
    is_cmp   = 1'b0;
    is_nop   = 1'b0;
    case (cmd)
      4'b0100: alu_op = 2'b00;
      4'b0010: alu_op = 2'b01;
      4'b0000: alu_op = 2'b10;
      4'b1100: alu_op = 2'b11;
      4'b1010: begin
        alu_op   = 2'b01;
        no_write = 1'b1;
        is_cmp   = 1'b1;
      end
      default: begin
        alu_op   = 2'b00;
        no_write = 1'b1;
        is_nop   = 1'b1;
      end
    endcase
  end

  assign flag_w[1] = (s_bit | is_cmp) & ~is_nop;
  assign flag_w[0] = (s_bit | is_cmp) & ~is_nop &
                     ((cmd == 4'b0100) | (cmd == 4'b0010) | is_cmp);

  // Flags are packed {Z,C,N,V}
  assign flag_z = flags_q[3];
  assign flag_c = flags_q[2];
  assign flag_n = flags_q[1];
  assign flag_v = flags_q[0];
  assign ge     = (flag_n == flag_v);

  always_comb begin
    cond_ok = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ok = flag_z;
      4'b0001: cond_ok = ~flag_z;
      4'b0010: cond_ok = flag_c;
      4'b0011: cond_ok = ~flag_c;
      4'b0100: cond_ok = flag_n;
      4'b0101: cond_ok = ~flag_n;
      4'b0110: cond_ok = flag_v;
      4'b0111: cond_ok = ~flag_v;
      4'b1000: cond_ok = flag_c & ~flag_z;
      4'b1001: cond_ok = ~flag_c | flag_z;
      4'b1010: cond_ok = ge;
      4'b1011: cond_ok = ~ge;
      4'b1100: cond_ok = ~flag_z & ge;
      4'b1101: cond_ok = flag_z | ~ge;
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = FETCH;
    condex_d = condex_q;
    flags_d  = flags_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        condex_d = cond_ok;
        case (bus.Op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = bus.Funct[5] ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = s_bit ? MEMREAD : MEMWRITE;
      MEMREAD: state_d = MEMWB;
      EXECR, EXECI: begin
        state_d = ALUWB;
        // N/Z and C/V halves are written independently
        if (condex_q && flag_w[1]) begin
          flags_d[3] = bus.ALUFlags[3];
          flags_d[1] = bus.ALUFlags[1];
        end
        if (condex_q && flag_w[0]) begin
          flags_d[2] = bus.ALUFlags[2];
          flags_d[0] = bus.ALUFlags[0];
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      condex_q <= 1'b0;
      flags_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      condex_q <= condex_d;
      flags_q  <= flags_d;
    end
  end

  logic pc_we, mem_we, reg_we, ir_we;

  always_comb begin
    pc_we          = 1'b0;
    mem_we         = 1'b0;
    reg_we         = 1'b0;
    ir_we          = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b00;
    bus.ALUControl = 2'b00;
    case (state_q)
      FETCH: begin
        ir_we         = 1'b1;
        pc_we         = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      MEMADR:  bus.ALUSrcB = 2'b01;
      MEMREAD: bus.AdrSrc  = 1'b1;
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        reg_we        = condex_q & ~pcs;
        pc_we         = condex_q & pcs;
      end
      MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        mem_we     = condex_q;
      end
      EXECR: bus.ALUControl = alu_op;
      EXECI: begin
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = alu_op;
      end
      ALUWB: begin
        reg_we = condex_q & ~no_write & ~pcs;
        pc_we  = condex_q & pcs & ~no_write;
      end
      BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        pc_we         = condex_q;
      end
      default: ;
    endcase
  end

  // Write enables are forced low for as long as reset is held
  assign bus.PCWrite  = pc_we  & ~reset;
  assign bus.MemWrite = mem_we & ~reset;
  assign bus.RegWrite = reg_we & ~reset;
  assign bus.IRWrite  = ir_we  & ~reset;

  assign bus.ImmSrc = bus.Op;
  assign bus.RegSrc = {bus.Op == 2'b01, bus.Op == 2'b10};
  assign bus.Flags  = flags_q;
  assign bus.State  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setins(input logic [3:0] c, input logic [1:0] op,
                        input logic [5:0] f, input logic [3:0] rd,
                        input logic [3:0] af);
    bus.Cond     = c;
    bus.Op       = op;
    bus.Funct    = f;
    bus.Rd       = rd;
    bus.ALUFlags = af;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    setins(4'b1110, 2'b00, 6'b000000, 4'd0, 4'b0000);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_state", int'(bus.State), 0);
    chk("rst_flags", int'(bus.Flags), 0);
    chk("rst_pcwrite", int'(bus.PCWrite), 0);
    chk("rst_irwrite", int'(bus.IRWrite), 0);
    chk("rst_alusrca", int'(bus.ALUSrcA), 1);
    chk("rst_alusrcb", int'(bus.ALUSrcB), 2);
    chk("rst_resultsrc", int'(bus.ResultSrc), 2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("fetch_irwrite", int'(bus.IRWrite), 1);
    chk("fetch_pcwrite", int'(bus.PCWrite), 1);

    // ADDS, ALUFlags Z=1 C=1
    setins(4'b1110, 2'b00, 6'b001001, 4'd2, 4'b1100);
    tick(); chk("adds_decode", int'(bus.State), 1);
    tick(); chk("adds_execr", int'(bus.State), 6);
    chk("adds_aluctl", int'(bus.ALUControl), 0);
    chk("adds_alusrcb", int'(bus.ALUSrcB), 0);
    tick(); chk("adds_aluwb", int'(bus.State), 8);
    chk("adds_regwrite", int'(bus.RegWrite), 1);
    chk("adds_flags", int'(bus.Flags), 4'b1100);
    tick(); chk("adds_fetch", int'(bus.State), 0);

    // SUBNE with Z=1: must not execute
    setins(4'b0001, 2'b00, 6'b000100, 4'd2, 4'b0000);
    tick(); tick();
    chk("subne_aluctl", int'(bus.ALUControl), 1);
    tick(); chk("subne_aluwb", int'(bus.State), 8);
    chk("subne_regwrite", int'(bus.RegWrite), 0);
    chk("subne_flags", int'(bus.Flags), 4'b1100);
    tick();

    // LDR r3
    setins(4'b1110, 2'b01, 6'b000001, 4'd3, 4'b0000);
    chk("ldr_regsrc", int'(bus.RegSrc), 2);
    tick(); chk("ldr_s1", int'(bus.State), 1);
    tick(); chk("ldr_s2", int'(bus.State), 2);
    chk("ldr_alusrcb", int'(bus.ALUSrcB), 1);
    tick(); chk("ldr_s3", int'(bus.State), 3);
    chk("ldr_adrsrc", int'(bus.AdrSrc), 1);
    chk("ldr_s3_regwrite", int'(bus.RegWrite), 0);
    tick(); chk("ldr_s4", int'(bus.State), 4);
    chk("ldr_regwrite", int'(bus.RegWrite), 1);
    chk("ldr_resultsrc", int'(bus.ResultSrc), 1);
    chk("ldr_pcwrite", int'(bus.PCWrite), 0);
    tick(); chk("ldr_s0", int'(bus.State), 0);

    // LDR pc
    setins(4'b1110, 2'b01, 6'b000001, 4'd15, 4'b0000);
    tick(); tick(); tick(); tick();
    chk("ldrpc_state", int'(bus.State), 4);
    chk("ldrpc_pcwrite", int'(bus.PCWrite), 1);
    chk("ldrpc_regwrite", int'(bus.RegWrite), 0);
    tick();

    // ADDS to set Flags={0,0,1,0}
    setins(4'b1110, 2'b00, 6'b001001, 4'd2, 4'b0010);
    tick(); tick(); tick();
    chk("adds2_flags", int'(bus.Flags), 4'b0010);
    tick();

    // CMP, ALUFlags={0,1,0,1}
    setins(4'b1110, 2'b00, 6'b010100, 4'd4, 4'b0101);
    tick(); tick();
    chk("cmp_aluctl", int'(bus.ALUControl), 1);
    tick(); chk("cmp_aluwb", int'(bus.State), 8);
    chk("cmp_regwrite", int'(bus.RegWrite), 0);
    chk("cmp_flags", int'(bus.Flags), 4'b0101);
    tick();

    // N=0 V=1: GE false, LT true
    setins(4'b1010, 2'b10, 6'b000000, 4'd0, 4'b0000);
    chk("bge_regsrc", int'(bus.RegSrc), 1);
    tick(); tick(); chk("bge_state", int'(bus.State), 9);
    chk("bge_pcwrite", int'(bus.PCWrite), 0);
    tick(); chk("bge_fetch", int'(bus.State), 0);
    setins(4'b1011, 2'b10, 6'b000000, 4'd0, 4'b0000);
    tick(); tick(); chk("blt_state", int'(bus.State), 9);
    chk("blt_pcwrite", int'(bus.PCWrite), 1);
    tick(); chk("blt_fetch", int'(bus.State), 0);

    // Illegal Op
    setins(4'b1110, 2'b11, 6'b000000, 4'd1, 4'b0000);
    tick(); chk("ill_decode", int'(bus.State), 1);
    chk("ill_memwrite", int'(bus.MemWrite), 0);
    chk("ill_regwrite", int'(bus.RegWrite), 0);
    tick(); chk("ill_fetch", int'(bus.State), 0);

    // Cond=1111 immediate ADDS: no flag or register write
    setins(4'b1111, 2'b00, 6'b101001, 4'd2, 4'b1111);
    tick(); tick(); chk("nv_execi", int'(bus.State), 7);
    chk("nv_alusrcb", int'(bus.ALUSrcB), 1);
    tick(); chk("nv_regwrite", int'(bus.RegWrite), 0);
    chk("nv_flags", int'(bus.Flags), 4'b0101);
    tick();

    // Cond=1111 STR
    setins(4'b1111, 2'b01, 6'b000000, 4'd2, 4'b0000);
    tick(); tick(); tick();
    chk("nvstr_state", int'(bus.State), 5);
    chk("nvstr_memwrite", int'(bus.MemWrite), 0);
    tick();

    // STR AL, reset in MEMWRITE
    setins(4'b1110, 2'b01, 6'b000000, 4'd2, 4'b0000);
    tick(); tick(); tick();
    chk("str_state", int'(bus.State), 5);
    chk("str_memwrite", int'(bus.MemWrite), 1);
    #1 reset = 1'b1;
    #1;
    chk("rstmid_memwrite", int'(bus.MemWrite), 0);
    chk("rstmid_state", int'(bus.State), 0);
    chk("rstmid_flags", int'(bus.Flags), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_state", int'(bus.State), 0);
    chk("rel_irwrite", int'(bus.IRWrite), 1);
    chk("rel_flags", int'(bus.Flags), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
